// File: rtl/vga_timing_pkg.sv
// Shared types and default timing for the VGA timing generator.
// Holds the per-axis phase enum, the 640x480@60 default timing constants
// and helpers that derive the total counts per axis.
package vga_timing_pkg;

    // Region an axis counter is currently in, in scan order.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // 640x480@60 with a 25 MHz pixel clock.
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CNT_W    = 16;

    // Counts per axis period (pixels per line or lines per frame).
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK
// phase FSM. Used once for pixels within a line and once for lines in a frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   advance      step the counter by one this edge
//   count        registered position, 0..TOTAL-1
//   phase        registered phase (vga_timing_pkg::phase_e encoding)
//   wrap         combinational: this edge takes count from TOTAL-1 to 0
//   in_active    registered: phase is ACTIVE
//   in_sync      registered: phase is SYNC
//   count_nxt    combinational next count (equals count when not advancing)
//   active_nxt   combinational: next phase is ACTIVE
//   sync_nxt     combinational: next phase is SYNC
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned W      = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic [1:0]   phase,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync,
    output logic [W-1:0] count_nxt,
    output logic         active_nxt,
    output logic         sync_nxt
);

    localparam int unsigned TOTAL       = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned LAST        = TOTAL - 1;
    localparam int unsigned FRONT_START = ACTIVE;
    localparam int unsigned SYNC_START  = ACTIVE + FP;
    localparam int unsigned BACK_START  = ACTIVE + FP + SYNC;

    logic [W-1:0] count_q, count_d;
    phase_e       phase_q, phase_d;
    logic         in_active_q, in_sync_q;

    // Position and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= W'(LAST);
            phase_q     <= PH_BACK;
            in_active_q <= 1'b0;
            in_sync_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            phase_q     <= phase_d;
            in_active_q <= (phase_d == PH_ACTIVE);
            in_sync_q   <= (phase_d == PH_SYNC);
        end
    end

    // Next count and phase. A phase change fires on the edge that enters the
    // first count of a region; empty regions share their start count with the
    // following region, so the size checks fall through and skip them.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap    = 1'b0;
        if (advance) begin
            if (count_q == W'(LAST)) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end

            if (count_d == '0) begin
                phase_d = PH_ACTIVE;
            end else if ((FP != 0) && (count_d == W'(FRONT_START))) begin
                phase_d = PH_FRONT;
            end else if ((SYNC != 0) && (count_d == W'(SYNC_START))) begin
                phase_d = PH_SYNC;
            end else if ((BP != 0) && (count_d == W'(BACK_START))) begin
                phase_d = PH_BACK;
            end
        end
    end

    assign count      = count_q;
    assign phase      = phase_q;
    assign in_active  = in_active_q;
    assign in_sync    = in_sync_q;
    assign count_nxt  = count_d;
    assign active_nxt = (phase_d == PH_ACTIVE);
    assign sync_nxt   = (phase_d == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator for the pixel-clock domain.
// Drives counters, sync pulses, display enable and active-area coordinates;
// every decode output is registered from next-state counts so it lines up
// with the h_count/v_count shown in the same cycle.
// Ports:
//   clk_25, rst_n      pixel clock, asynchronous active-low reset
//   pix_en             clock enable; everything holds while low
//   h_count, v_count   raw positions, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   hsync, vsync       sync pulses, asserted level set by H/V_SYNC_POL
//   de                 display enable (inside the active area)
//   x, y               active-area coordinates, 0 outside the active area
//   line_end           high while h_count is the last count of the line
//   frame_start        high at (0,0); present only with VGA_TIMING_FRAME_STROBE_EN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_end
`ifdef VGA_TIMING_FRAME_STROBE_EN
    ,
    output logic             frame_start
`endif
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic [1:0]       h_phase, v_phase;
    logic             h_wrap, v_wrap;
    logic             h_in_active, h_in_sync, v_in_active, v_in_sync;
    logic             h_active_nxt, h_sync_nxt, v_active_nxt, v_sync_nxt;
    logic             v_advance;

    // Registered phase flags are kept for debug visibility only.
    logic unused_phase_bits;
    assign unused_phase_bits = ^{h_phase, v_phase, v_wrap,
                                 h_in_active, h_in_sync, v_in_active, v_in_sync};

    // Lines step only on the edge that wraps the pixel counter.
    assign v_advance = pix_en & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (CNT_W)
    ) u_h_axis (
        .clk        (clk_25),
        .rst_n      (rst_n),
        .advance    (pix_en),
        .count      (h_count),
        .phase      (h_phase),
        .wrap       (h_wrap),
        .in_active  (h_in_active),
        .in_sync    (h_in_sync),
        .count_nxt  (h_nxt),
        .active_nxt (h_active_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (CNT_W)
    ) u_v_axis (
        .clk        (clk_25),
        .rst_n      (rst_n),
        .advance    (v_advance),
        .count      (v_count),
        .phase      (v_phase),
        .wrap       (v_wrap),
        .in_active  (v_in_active),
        .in_sync    (v_in_sync),
        .count_nxt  (v_nxt),
        .active_nxt (v_active_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             line_end_q, line_end_d;

    // Decode from next-state counts; with pix_en low the next state equals
    // the current one, so re-registering holds every output.
    always_comb begin
        hsync_d    = ~H_SYNC_POL;
        vsync_d    = ~V_SYNC_POL;
        de_d       = 1'b0;
        x_d        = '0;
        y_d        = '0;
        line_end_d = 1'b0;
        if (h_sync_nxt) hsync_d = H_SYNC_POL;
        if (v_sync_nxt) vsync_d = V_SYNC_POL;
        de_d = h_active_nxt & v_active_nxt;
        if (de_d) begin
            x_d = h_nxt;
            y_d = v_nxt;
        end
        line_end_d = (h_nxt == CNT_W'(H_TOTAL - 1));
    end

    // Reset mirrors the (H_TOTAL-1, V_TOTAL-1) counter state: syncs idle,
    // outside the active area, on the last count of a line.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q    <= ~H_SYNC_POL;
            vsync_q    <= ~V_SYNC_POL;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            line_end_q <= 1'b1;
        end else begin
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_end_q <= line_end_d;
        end
    end

    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign de       = de_q;
    assign x        = x_q;
    assign y        = y_q;
    assign line_end = line_end_q;

`ifdef VGA_TIMING_FRAME_STROBE_EN
    logic frame_start_q, frame_start_d;

    // Strobe for the first pixel of each frame.
    always_comb begin
        frame_start_d = (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny
// timing instance (7x5 with an empty horizontal front porch).
module tb_vga_timing_gen;

    logic clk_25 = 1'b0;
    logic rst_n  = 1'b0;
    logic pe_a   = 1'b0;
    logic pe_b   = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #20 clk_25 = ~clk_25;

    // Default instance.
    logic [15:0] h_a, v_a, x_a, y_a;
    logic        hs_a, vs_a, de_a, le_a;
    // Small instance.
    logic [3:0]  h_b, v_b, x_b, y_b;
    logic        hs_b, vs_b, de_b, le_b;
`ifdef VGA_TIMING_FRAME_STROBE_EN
    logic        fs_a, fs_b;
`endif

    vga_timing_gen u_dut (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .pix_en   (pe_a),
        .h_count  (h_a),
        .v_count  (v_a),
        .hsync    (hs_a),
        .vsync    (vs_a),
        .de       (de_a),
        .x        (x_a),
        .y        (y_a),
        .line_end (le_a)
`ifdef VGA_TIMING_FRAME_STROBE_EN
        ,
        .frame_start (fs_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE   (4),
        .H_FP       (0),
        .H_SYNC     (2),
        .H_BP       (1),
        .V_ACTIVE   (2),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (1),
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b0),
        .CNT_W      (4)
    ) u_small (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .pix_en   (pe_b),
        .h_count  (h_b),
        .v_count  (v_b),
        .hsync    (hs_b),
        .vsync    (vs_b),
        .de       (de_b),
        .x        (x_b),
        .y        (y_b),
        .line_end (le_b)
`ifdef VGA_TIMING_FRAME_STROBE_EN
        ,
        .frame_start (fs_b)
`endif
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic test_reset();
        logic [67:0] got, exp;
        rst_n = 1'b0;
        pe_a  = 1'b1;
        pe_b  = 1'b0;
        step();
        step();
        got = {h_a, v_a, hs_a, vs_a, de_a, x_a, y_a};
        exp = {16'd799, 16'd524, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        n_cmp++;
        if (got[67:1] !== exp[67:1]) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", got[67:1], exp[67:1]);
        end
`ifdef VGA_TIMING_FRAME_STROBE_EN
        n_cmp++;
        if (fs_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_frame_start: got %b want 0", fs_a);
        end
`endif
        rst_n = 1'b1;
        step();
        got = {h_a, v_a, hs_a, vs_a, de_a, x_a, y_a, le_a};
        exp = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL first_edge: got %h want %h", got, exp);
        end
`ifdef VGA_TIMING_FRAME_STROBE_EN
        n_cmp++;
        if (fs_a !== 1'b1) begin
            n_bad++;
            $display("FAIL first_frame_start: got %b want 1", fs_a);
        end
`endif
    endtask

    // One full line from (0,0) to (0,1) on the default timing.
    task automatic test_line();
        logic [67:0] got, exp;
        int eh, ev, hs_low;
        logic ede, ehs;
        hs_low = 0;
        for (int i = 1; i <= 800; i++) begin
            step();
            eh  = i % 800;
            ev  = i / 800;
            ede = (eh < 640) && (ev < 480);
            ehs = !((eh >= 656) && (eh <= 751));
            exp = {16'(eh), 16'(ev), ehs, 1'b1, ede,
                   16'(ede ? eh : 0), 16'(ede ? ev : 0), (eh == 799)};
            got = {h_a, v_a, hs_a, vs_a, de_a, x_a, y_a, le_a};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL line i=%0d: got %h want %h", i, got, exp);
            end
            if (hs_a === 1'b0) hs_low++;
        end
        n_cmp++;
        if (hs_low !== 96) begin
            n_bad++;
            $display("FAIL hsync_width: got %0d want 96", hs_low);
        end
`ifdef VGA_TIMING_FRAME_STROBE_EN
        n_cmp++;
        if (fs_a !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_start_line1: got %b want 0", fs_a);
        end
`endif
    endtask

    // Alternating enable: every other edge is a hold.
    task automatic test_pix_en();
        logic [67:0] got, exp;
        int eh, ev;
        logic ede, ehs, evs;
        eh = 0;
        ev = 1;
        for (int c = 0; c < 1600; c++) begin
            pe_a = (c % 2 == 0);
            step();
            if (pe_a) begin
                if (eh == 799) begin
                    eh = 0;
                    ev = (ev == 524) ? 0 : ev + 1;
                end else begin
                    eh = eh + 1;
                end
            end
            ede = (eh < 640) && (ev < 480);
            ehs = !((eh >= 656) && (eh <= 751));
            evs = !((ev >= 490) && (ev <= 491));
            exp = {16'(eh), 16'(ev), ehs, evs, ede,
                   16'(ede ? eh : 0), 16'(ede ? ev : 0), (eh == 799)};
            got = {h_a, v_a, hs_a, vs_a, de_a, x_a, y_a, le_a};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL pix_en c=%0d: got %h want %h", c, got, exp);
            end
        end
        pe_a = 1'b0;
        n_cmp++;
        if ({h_a, v_a} !== {16'd0, 16'd2}) begin
            n_bad++;
            $display("FAIL pix_en_advances: got h=%0d v=%0d want h=0 v=2", h_a, v_a);
        end
    endtask

    // Full frame on the small timing, ending with the (6,4)->(0,0) wrap.
    task automatic test_small_frame();
        logic [19:0] got, exp;
        int eh, ev, fs_cnt;
        logic ede, ehs, evs;
        fs_cnt = 0;
        pe_b = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            step();
            eh  = (k - 1) % 7;
            ev  = ((k - 1) / 7) % 5;
            ede = (eh < 4) && (ev < 2);
            ehs = (eh >= 4) && (eh <= 5);
            evs = (ev != 3);
            exp = {4'(eh), 4'(ev), ehs, evs, ede,
                   4'(ede ? eh : 0), 4'(ede ? ev : 0), (eh == 6)};
            got = {h_b, v_b, hs_b, vs_b, de_b, x_b, y_b, le_b};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL small k=%0d: got %h want %h", k, got, exp);
            end
`ifdef VGA_TIMING_FRAME_STROBE_EN
            if (k <= 35 && fs_b === 1'b1) fs_cnt++;
`endif
        end
`ifdef VGA_TIMING_FRAME_STROBE_EN
        n_cmp++;
        if (fs_cnt !== 1) begin
            n_bad++;
            $display("FAIL small_frame_start_count: got %0d want 1", fs_cnt);
        end
`endif
    endtask

    // Reset asserted mid-pulse must clear outputs without a clock edge.
    task automatic test_reset_midframe();
        // Small instance sits at (0,0); move to (2,3) where vsync is active.
        for (int k = 0; k < 23; k++) step();
        n_cmp++;
        if ({h_b, v_b, vs_b} !== {4'd2, 4'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL pre_reset_pos: got h=%0d v=%0d vs=%b want h=2 v=3 vs=0",
                     h_b, v_b, vs_b);
        end
        #5;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({h_b, v_b, hs_b, vs_b, de_b, le_b} !== {4'd6, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset_small: got h=%0d v=%0d hs=%b vs=%b de=%b le=%b want 6 4 0 1 0 1",
                     h_b, v_b, hs_b, vs_b, de_b, le_b);
        end
        n_cmp++;
        if ({h_a, v_a, vs_a, de_a} !== {16'd799, 16'd524, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset_default: got h=%0d v=%0d vs=%b de=%b want 799 524 1 0",
                     h_a, v_a, vs_a, de_a);
        end
        step();
        n_cmp++;
        if ({h_b, v_b, vs_b} !== {4'd6, 4'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_hold: got h=%0d v=%0d vs=%b want 6 4 1", h_b, v_b, vs_b);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pix_en();
        test_small_frame();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
